// File: rtl/cnn_infer_engine.sv
// Single-conv-layer plus fully-connected inference engine: one MAC per cycle, weights streamed from external memory.
// Optional build macro CNN_INFER_RELU_EN clamps negative conv features to zero before the FC stage.
module cnn_infer_engine #(
  parameter int IMG_DIM = 28,
  parameter int KER_DIM = 3,
  parameter int N_CLASS = 10,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [DATA_W*IMG_DIM*IMG_DIM-1:0]     i_image,
  input  logic [DATA_W*KER_DIM*KER_DIM-1:0]     i_kernel,
  input  logic [DATA_W-1:0]                     bias,
  output logic                                  w_rd_en,
  output logic [$clog2((IMG_DIM-KER_DIM+1)*(IMG_DIM-KER_DIM+1)*N_CLASS)-1:0] w_addr,
  input  logic [DATA_W-1:0]                     w_rd_data,
  output logic                                  busy,
  output logic [ACC_W*N_CLASS-1:0]              o_output_data,
  output logic                                  done
);

  localparam int O_DIM    = IMG_DIM - KER_DIM + 1;
  localparam int F        = O_DIM * O_DIM;
  localparam int AW       = $clog2(F * N_CLASS);
  localparam int P_W      = (F > 1) ? $clog2(F) : 1;
  localparam int PC_W     = (O_DIM > 1) ? $clog2(O_DIM) : 1;
  localparam int K_W      = (KER_DIM > 1) ? $clog2(KER_DIM) : 1;
  localparam int FC_W     = $clog2(N_CLASS + 1);
  localparam int IMG_BITS = DATA_W * IMG_DIM * IMG_DIM;
  localparam int KER_BITS = DATA_W * KER_DIM * KER_DIM;
  localparam int IMG_IW   = $clog2(IMG_BITS);
  localparam int KER_IW   = $clog2(KER_BITS);

  localparam logic [P_W-1:0]  P_ONE  = P_W'(1'b1);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);
  localparam logic [K_W-1:0]  K_ONE  = K_W'(1'b1);
  localparam logic [FC_W-1:0] FC_ONE = FC_W'(1'b1);

  typedef enum logic [2:0] {IDLE_S, CONV_S, BIAS_S, FC_S, DONE_S} state_t;

  state_t                    state_r, state_nx_s;
  logic [IMG_BITS-1:0]       img_r;
  logic [KER_BITS-1:0]       ker_r;
  logic [DATA_W-1:0]         bias_r;
  logic [K_W-1:0]            kr_r, kc_r;
  logic [PC_W-1:0]           pr_r, pc_r;
  logic [P_W-1:0]            p_r;
  logic [FC_W-1:0]           fc_cnt_r;
  logic signed [ACC_W-1:0]   sum_r, feature_r;
  logic signed [ACC_W-1:0]   acc_r [N_CLASS];
  logic signed [ACC_W-1:0]   out_r [N_CLASS];
  logic signed [ACC_W-1:0]   acc_next_s [N_CLASS];
  logic                      w_rd_en_r, busy_r, done_r;
  logic [AW-1:0]             w_addr_r;

  logic                      conv_last_s, fc_last_s, p_last_s, first_tap_s;
  logic                      rd_en_nx_s;
  logic [AW-1:0]             addr_nx_s, p_base_s;
  logic [IMG_IW-1:0]         pix_base_s;
  logic [KER_IW-1:0]         ker_base_s;
  logic [DATA_W-1:0]         pixel_s, tap_s;
  logic signed [ACC_W-1:0]   conv_prod_s, bias_ext_s, feat_raw_s, feat_s, wt_ext_s, fc_prod_s;

  assign conv_last_s = (kr_r == K_W'(KER_DIM - 1)) && (kc_r == K_W'(KER_DIM - 1));
  assign first_tap_s = (kr_r == {K_W{1'b0}}) && (kc_r == {K_W{1'b0}});
  assign fc_last_s   = (fc_cnt_r == FC_W'(N_CLASS));
  assign p_last_s    = (p_r == P_W'(F - 1));
  assign p_base_s    = AW'(p_r) * AW'(N_CLASS);

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE_S: begin
        if (start) state_nx_s = CONV_S;
        else       state_nx_s = IDLE_S;
      end
      CONV_S: begin
        if (conv_last_s) state_nx_s = BIAS_S;
        else             state_nx_s = CONV_S;
      end
      BIAS_S: state_nx_s = FC_S;
      FC_S: begin
        if (fc_last_s) begin
          if (p_last_s) state_nx_s = DONE_S;
          else          state_nx_s = CONV_S;
        end else begin
          state_nx_s = FC_S;
        end
      end
      DONE_S:  state_nx_s = IDLE_S;
      default: state_nx_s = IDLE_S;
    endcase
  end

  // Weight request for the coming cycle, so the strobe and address leave from flops
  always_comb begin
    rd_en_nx_s = 1'b0;
    addr_nx_s  = {AW{1'b0}};
    if (state_r == BIAS_S) begin
      rd_en_nx_s = 1'b1;
      addr_nx_s  = p_base_s;
    end else if ((state_r == FC_S) && (fc_cnt_r < FC_W'(N_CLASS - 1))) begin
      rd_en_nx_s = 1'b1;
      addr_nx_s  = p_base_s + AW'(fc_cnt_r + FC_ONE);
    end else begin
      rd_en_nx_s = 1'b0;
      addr_nx_s  = {AW{1'b0}};
    end
  end

  // Conv operand selection, bias/activation and FC product
  always_comb begin
    pix_base_s  = ((IMG_IW'(pr_r) + IMG_IW'(kr_r)) * IMG_IW'(IMG_DIM)
                   + IMG_IW'(pc_r) + IMG_IW'(kc_r)) * IMG_IW'(DATA_W);
    ker_base_s  = (KER_IW'(kr_r) * KER_IW'(KER_DIM) + KER_IW'(kc_r)) * KER_IW'(DATA_W);
    pixel_s     = img_r[pix_base_s +: DATA_W];
    tap_s       = ker_r[ker_base_s +: DATA_W];
    conv_prod_s = $signed({{(ACC_W-DATA_W){1'b0}}, pixel_s})
                * $signed({{(ACC_W-DATA_W){tap_s[DATA_W-1]}}, tap_s});
    bias_ext_s  = $signed({{(ACC_W-DATA_W){bias_r[DATA_W-1]}}, bias_r});
    feat_raw_s  = sum_r + bias_ext_s;
`ifdef CNN_INFER_RELU_EN
    if (feat_raw_s[ACC_W-1]) feat_s = {ACC_W{1'b0}};
    else                     feat_s = feat_raw_s;
`else
    feat_s      = feat_raw_s;
`endif
    wt_ext_s    = $signed({{(ACC_W-DATA_W){w_rd_data[DATA_W-1]}}, w_rd_data});
    fc_prod_s   = feature_r * wt_ext_s;
  end

  // Weight data for class c arrives on FC cycle c+1
  always_comb begin
    acc_next_s = acc_r;
    for (int i = 0; i < N_CLASS; i++) begin
      if ((state_r == FC_S) && (fc_cnt_r == FC_W'(i + 1))) acc_next_s[i] = acc_r[i] + fc_prod_s;
      else                                                  acc_next_s[i] = acc_r[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE_S;
    else       state_r <= state_nx_s;
  end

  // Operand snapshot taken only when a start is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      img_r  <= {IMG_BITS{1'b0}};
      ker_r  <= {KER_BITS{1'b0}};
      bias_r <= {DATA_W{1'b0}};
    end else if ((state_r == IDLE_S) && start) begin
      img_r  <= i_image;
      ker_r  <= i_kernel;
      bias_r <= bias;
    end
  end

  // Kernel, output-position and FC cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      kr_r     <= {K_W{1'b0}};
      kc_r     <= {K_W{1'b0}};
      pr_r     <= {PC_W{1'b0}};
      pc_r     <= {PC_W{1'b0}};
      p_r      <= {P_W{1'b0}};
      fc_cnt_r <= {FC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE_S: begin
          if (start) begin
            kr_r     <= {K_W{1'b0}};
            kc_r     <= {K_W{1'b0}};
            pr_r     <= {PC_W{1'b0}};
            pc_r     <= {PC_W{1'b0}};
            p_r      <= {P_W{1'b0}};
            fc_cnt_r <= {FC_W{1'b0}};
          end
        end
        CONV_S: begin
          if (kc_r == K_W'(KER_DIM - 1)) begin
            kc_r <= {K_W{1'b0}};
            if (kr_r == K_W'(KER_DIM - 1)) kr_r <= {K_W{1'b0}};
            else                           kr_r <= kr_r + K_ONE;
          end else begin
            kc_r <= kc_r + K_ONE;
          end
        end
        BIAS_S: fc_cnt_r <= {FC_W{1'b0}};
        FC_S: begin
          if (fc_last_s) begin
            fc_cnt_r <= {FC_W{1'b0}};
            if (!p_last_s) begin
              p_r <= p_r + P_ONE;
              if (pc_r == PC_W'(O_DIM - 1)) begin
                pc_r <= {PC_W{1'b0}};
                pr_r <= pr_r + PC_ONE;
              end else begin
                pc_r <= pc_r + PC_ONE;
              end
            end
          end else begin
            fc_cnt_r <= fc_cnt_r + FC_ONE;
          end
        end
        DONE_S:  fc_cnt_r <= {FC_W{1'b0}};
        default: fc_cnt_r <= {FC_W{1'b0}};
      endcase
    end
  end

  // Convolution MAC and bias/activation stage
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r     <= {ACC_W{1'b0}};
      feature_r <= {ACC_W{1'b0}};
    end else begin
      if (state_r == CONV_S) sum_r <= (first_tap_s ? {ACC_W{1'b0}} : sum_r) + conv_prod_s;
      if (state_r == BIAS_S) feature_r <= feat_s;
    end
  end

  // Class accumulators; the result register picks up the final sums as DONE is entered
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CLASS; i++) begin
        acc_r[i] <= {ACC_W{1'b0}};
        out_r[i] <= {ACC_W{1'b0}};
      end
    end else begin
      if ((state_r == IDLE_S) && start) begin
        for (int i = 0; i < N_CLASS; i++) acc_r[i] <= {ACC_W{1'b0}};
      end else begin
        acc_r <= acc_next_s;
      end
      if ((state_r == FC_S) && fc_last_s && p_last_s) out_r <= acc_next_s;
    end
  end

  // Registered interface outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      w_rd_en_r <= 1'b0;
      w_addr_r  <= {AW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      w_rd_en_r <= rd_en_nx_s;
      w_addr_r  <= addr_nx_s;
      busy_r    <= (state_nx_s != IDLE_S);
      done_r    <= (state_nx_s == DONE_S);
    end
  end

  assign w_rd_en = w_rd_en_r;
  assign w_addr  = w_addr_r;
  assign busy    = busy_r;
  assign done    = done_r;

  for (genvar g = 0; g < N_CLASS; g++) begin : g_out
    assign o_output_data[g*ACC_W +: ACC_W] = out_r[g];
  end

endmodule

// File: tb/tb_cnn_infer_engine.sv
// Self-checking bench for cnn_infer_engine: directed and random images scored against a loop-nest reference model.
module tb_cnn_infer_engine;

  localparam int IMG_DIM = 28;
  localparam int KER_DIM = 3;
  localparam int N_CLASS = 10;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int O_DIM   = IMG_DIM - KER_DIM + 1;
  localparam int F       = O_DIM * O_DIM;
  localparam int AW      = $clog2(F * N_CLASS);
  localparam int LAT     = F * (KER_DIM * KER_DIM + N_CLASS + 2);

  logic                              clk;
  logic                              reset;
  logic                              start;
  logic [DATA_W*IMG_DIM*IMG_DIM-1:0] i_image;
  logic [DATA_W*KER_DIM*KER_DIM-1:0] i_kernel;
  logic [DATA_W-1:0]                 bias;
  logic                              w_rd_en;
  logic [AW-1:0]                     w_addr;
  logic [DATA_W-1:0]                 w_rd_data;
  logic                              busy;
  logic [ACC_W*N_CLASS-1:0]          o_output_data;
  logic                              done;

  int pix [IMG_DIM][IMG_DIM];
  int ker [KER_DIM][KER_DIM];
  int bias_v;
  int wmem [F*N_CLASS];
  int exp_score [N_CLASS];
  int last_out [N_CLASS];
  int total = 0;
  int bad = 0;
  int addr_err = 0;
  int exp_addr = 0;

  cnn_infer_engine #(
    .IMG_DIM(IMG_DIM), .KER_DIM(KER_DIM), .N_CLASS(N_CLASS), .DATA_W(DATA_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .i_image(i_image), .i_kernel(i_kernel),
    .bias(bias), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .busy(busy), .o_output_data(o_output_data), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // weight memory: one-cycle read latency
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= 8'(wmem[w_addr]);
  end

  // reads must walk 0,1,2,... across a run
  always @(posedge clk) begin
    if (reset || !busy) begin
      exp_addr <= 0;
    end else if (w_rd_en) begin
      if (w_addr != AW'(exp_addr)) addr_err <= addr_err + 1;
      exp_addr <= exp_addr + 1;
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int score_of(input int c);
    logic signed [ACC_W-1:0] s;
    s = o_output_data[c*ACC_W +: ACC_W];
    return int'(s);
  endfunction

  task automatic pack_inputs();
    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++)
        i_image[(r*IMG_DIM+c)*DATA_W +: DATA_W] = 8'(pix[r][c]);
    for (int r = 0; r < KER_DIM; r++)
      for (int c = 0; c < KER_DIM; c++)
        i_kernel[(r*KER_DIM+c)*DATA_W +: DATA_W] = 8'(ker[r][c]);
    bias = 8'(bias_v);
  endtask

  task automatic model();
    int sum, feat;
    for (int c = 0; c < N_CLASS; c++) exp_score[c] = 0;
    for (int pr = 0; pr < O_DIM; pr++) begin
      for (int pc = 0; pc < O_DIM; pc++) begin
        sum = 0;
        for (int kr = 0; kr < KER_DIM; kr++)
          for (int kc = 0; kc < KER_DIM; kc++)
            sum += pix[pr+kr][pc+kc] * ker[kr][kc];
        feat = sum + bias_v;
`ifdef CNN_INFER_RELU_EN
        if (feat < 0) feat = 0;
`endif
        for (int c = 0; c < N_CLASS; c++)
          exp_score[c] += feat * wmem[(pr*O_DIM+pc)*N_CLASS + c];
      end
    end
  endtask

  task automatic set_uniform(input int pv, input int kv, input int bv, input int wv);
    for (int r = 0; r < IMG_DIM; r++) for (int c = 0; c < IMG_DIM; c++) pix[r][c] = pv;
    for (int r = 0; r < KER_DIM; r++) for (int c = 0; c < KER_DIM; c++) ker[r][c] = kv;
    for (int a = 0; a < F*N_CLASS; a++) wmem[a] = wv;
    bias_v = bv;
  endtask

  task automatic set_random();
    for (int r = 0; r < IMG_DIM; r++) for (int c = 0; c < IMG_DIM; c++) pix[r][c] = int'($urandom_range(255));
    for (int r = 0; r < KER_DIM; r++) for (int c = 0; c < KER_DIM; c++) ker[r][c] = int'($urandom_range(255)) - 128;
    for (int a = 0; a < F*N_CLASS; a++) wmem[a] = int'($urandom_range(255)) - 128;
    bias_v = int'($urandom_range(255)) - 128;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_rden"}, w_rd_en, 0);
    check_val({tag, "_addr"}, w_addr, 0);
    check_val({tag, "_out_or"}, |o_output_data, 0);
  endtask

  task automatic run_case(input string name, input bit repulse, input bit scramble, input int abort_at);
    int cyc;
    bit got;
    pack_inputs();
    model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      for (int b = 0; b < IMG_DIM*IMG_DIM; b++) i_image[b*DATA_W +: DATA_W] = 8'($urandom);
      i_kernel = {$urandom, $urandom, $urandom};
      bias = 8'($urandom);
    end
    cyc = 0;
    got = 1'b0;
    while (cyc < LAT + 50 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (repulse && cyc == 100) start = 1'b1;
      if (cyc == 101) start = 1'b0;
      if (cyc == 200) begin
        check_val({name, "_busy_mid"}, busy, 1);
        check_val({name, "_hold0"}, score_of(0), last_out[0]);
        check_val({name, "_hold9"}, score_of(N_CLASS-1), last_out[N_CLASS-1]);
      end
      if (abort_at != 0 && cyc == abort_at) begin
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check_reset_state({name, "_rst"});
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < N_CLASS; c++) last_out[c] = 0;
        return;
      end
      if (done) got = 1'b1;
    end
    check_val({name, "_done_seen"}, got, 1);
    check_val({name, "_latency"}, cyc, LAT);
    check_val({name, "_reads"}, exp_addr, F*N_CLASS);
    for (int c = 0; c < N_CLASS; c++)
      check_val($sformatf("%s_score%0d", name, c), score_of(c), exp_score[c]);
    last_out = exp_score;
    @(posedge clk); #1;
    check_val({name, "_done_drop"}, done, 0);
    check_val({name, "_idle"}, busy, 0);
    check_val({name, "_keep0"}, score_of(0), last_out[0]);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    i_image = '0;
    i_kernel = '0;
    bias = 8'h00;
    for (int c = 0; c < N_CLASS; c++) last_out[c] = 0;
    set_uniform(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    reset = 1'b0;
    @(posedge clk); #1;

    set_uniform(1, 1, 0, 1);
    run_case("ones", 1'b1, 1'b0, 0);
    check_val("ones_ref", exp_score[5], 6084);

    set_uniform(0, 0, 0, 0);
    pix[0][0] = 5;
    ker[0][0] = 2;
    wmem[3] = 1;
    run_case("single", 1'b0, 1'b0, 0);

    set_uniform(1, 1, -20, 1);
    run_case("negbias", 1'b0, 1'b0, 0);

    set_random();
    run_case("rand", 1'b0, 1'b1, 0);

    set_uniform(1, 1, 0, 1);
    run_case("abort", 1'b0, 1'b0, 5000);
    run_case("after_rst", 1'b0, 1'b0, 0);

    check_val("addr_seq", addr_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_infer_engine.md
CNN_INFER_ENGINE -- requirements
Module: cnn_infer_engine

Interface
REQ-001 SHALL have parameter IMG_DIM, default 28, meaning square input image side.
REQ-002 SHALL have parameter KER_DIM, default 3, meaning square kernel side; conv output side O = IMG_DIM-KER_DIM+1 (26), feature count F = O*O (676).
REQ-003 SHALL have parameter N_CLASS, default 10, meaning number of FC outputs.
REQ-004 SHALL have parameter DATA_W, default 8, meaning pixel, kernel, bias and weight width.
REQ-005 SHALL have parameter ACC_W, default 32, meaning accumulator and output width.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; one clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit, meaning request to begin inference.
REQ-009 SHALL have port i_image, input, DATA_W*IMG_DIM*IMG_DIM bits, meaning unsigned pixels; pixel (r,c) at bits [(r*IMG_DIM+c)*DATA_W +: DATA_W].
REQ-010 SHALL have port i_kernel, input, DATA_W*KER_DIM*KER_DIM bits, meaning signed taps, row-major at [(kr*KER_DIM+kc)*DATA_W +: DATA_W].
REQ-011 SHALL have port bias, input, DATA_W bits, meaning signed bias added to every conv output.
REQ-012 SHALL have port w_rd_en, output, 1 bit, meaning weight memory read strobe.
REQ-013 SHALL have port w_addr, output, clog2(F*N_CLASS) bits, meaning weight address p*N_CLASS+c.
REQ-014 SHALL have port w_rd_data, input, DATA_W bits, meaning signed weight, valid exactly one cycle after w_rd_en.
REQ-015 SHALL have port busy, output, 1 bit, meaning high in any state other than IDLE.
REQ-016 SHALL have port o_output_data, output, ACC_W*N_CLASS bits, meaning signed class score c at [c*ACC_W +: ACC_W].
REQ-017 SHALL have port done, output, 1 bit, meaning one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, CONV, BIAS, FC, DONE.
REQ-019 In IDLE, start=1 SHALL latch i_image, i_kernel, bias, clear all N_CLASS accumulators, set p=0, and enter CONV; start in any other state SHALL be ignored.
REQ-020 CONV SHALL last KER_DIM*KER_DIM cycles, one signed MAC per cycle: sum += zero-extended pixel(pr+kr,pc+kc) * kernel(kr,kc), where pr=p/O, pc=p%O; then BIAS.
REQ-021 BIAS SHALL last 1 cycle: feature = sum + sign-extended bias, in ACC_W bits.
REQ-022 FC SHALL last N_CLASS+1 cycles: cycles 0..N_CLASS-1 assert w_rd_en with w_addr=p*N_CLASS+c; cycles 1..N_CLASS add feature*w_rd_data to acc[c-1].
REQ-023 All arithmetic SHALL be signed two's-complement truncated to ACC_W, wrapping modulo 2^ACC_W without saturation.
REQ-024 After FC, p<F-1 SHALL increment p and return to CONV; p=F-1 SHALL enter DONE.
REQ-025 Latency from start-accept edge to done SHALL be F*(KER_DIM*KER_DIM+N_CLASS+2) cycles (14196 at defaults).
REQ-026 DONE SHALL last 1 cycle: copy acc to o_output_data, pulse done=1, then IDLE.
REQ-027 o_output_data SHALL change only in DONE and otherwise hold its last value.
REQ-028 w_rd_en SHALL be 0 outside FC issue cycles.
REQ-029 Changes on i_image, i_kernel or bias after start-accept SHALL not affect the result.

Reset
REQ-030 reset=1 SHALL, on the next edge, force IDLE and set busy=0, done=0, w_rd_en=0, w_addr=0, o_output_data=0, acc=0, p=0, even mid-operation.
REQ-031 reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 With macro CNN_INFER_RELU_EN defined, BIAS SHALL clamp a negative feature to 0; without it, the feature SHALL pass unclamped.

Verification
REQ-033 Defaults; all pixels=1, taps=1, bias=0, all weights=1 -> done at cycle 14196 after start-accept; every score=6084.
REQ-034 Pixel(0,0)=5, others 0; tap(0,0)=2, others 0; bias=0; weight addr 3=1, others 0 -> score[3]=10, all other scores 0.
REQ-035 Scenario of REQ-033 with bias=-20 -> without CNN_INFER_RELU_EN every score=-7436; with it every score=0.
REQ-036 start pulsed again at cycle 100 of a run -> ignored; done at cycle 14196, scores unchanged from REQ-033.
REQ-037 reset at cycle 5000 -> next cycle busy=0, all outputs 0; a new start then completes normally with REQ-033 values.
